// File: rtl/bus_ctrl.sv
// bus_ctrl: arbitrates the single external memory port between the IF stage
// (instruction fetch) and the MEM stage (load/store) of the 6-stage pipeline.
// A 3-state FSM (IDLE / MEM_ACC / IF_ACC) runs one bus cycle at a time.
// The block also drives the pipeline stall vector while an access is pending.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   if_*            fetch request/address in, instruction data/ack pulse out
//   mem_*           load/store request/we/sel/addr/wdata in, rdata/ack pulse out
//   bus_*           external bus: cyc/we/sel/addr/wdata out, rdata/ack in
//   stall_o         {wb,mem,ex,id,if,pc}; a 1 holds that stage
//   err_o           sticky bus-timeout flag
//
// Optional feature: define BUS_CTRL_TIMEOUT_EN to enable a watchdog.
// It aborts a bus cycle after TIMEOUT_CYCLES cycles without bus_ack_i and
// returns data 0 with err_o set. When the macro is undefined, err_o is tied 0.
module bus_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              bus_cyc_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic [5:0]        stall_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, MEM_ACC, IF_ACC} state_t;

  state_t state, state_nx;
  logic   start_mem, start_if, done, timeout;

`ifdef BUS_CTRL_TIMEOUT_EN
  logic [31:0] cnt;
  // The last cycle of a timed-out access is the one where the count reaches
  // TIMEOUT_CYCLES-1, which keeps bus_cyc_o high for exactly TIMEOUT_CYCLES cycles.
  assign timeout = bus_cyc_o && !bus_ack_i && (cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    start_mem = 1'b0;
    start_if  = 1'b0;
    done      = 1'b0;
    state_nx  = state;
    case (state)
      IDLE: begin
        // Requests are ignored during the ack pulse, so a requester that is
        // still holding req in that cycle does not re-trigger.
        if (!if_ack_o && !mem_ack_o) begin
          if (mem_req_i) begin
            start_mem = 1'b1;
            state_nx  = MEM_ACC;
          end else if (if_req_i) begin
            start_if = 1'b1;
            state_nx = IF_ACC;
          end
        end
      end
      MEM_ACC, IF_ACC: begin
        done = bus_ack_i || timeout;
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus_cyc_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      mem_ack_o   <= 1'b0;
      if_data_o   <= '0;
      mem_rdata_o <= '0;
    end else begin
      state     <= state_nx;
      bus_cyc_o <= (state_nx != IDLE);
      if_ack_o  <= (state == IF_ACC) && done;
      mem_ack_o <= (state == MEM_ACC) && done;
      if (start_mem) begin
        bus_we_o    <= mem_we_i;
        bus_sel_o   <= mem_sel_i;
        bus_addr_o  <= mem_addr_i;
        bus_wdata_o <= mem_wdata_i;
      end else if (start_if) begin
        bus_we_o    <= 1'b0;
        bus_sel_o   <= 4'hF;
        bus_addr_o  <= if_addr_i;
      end
      if (state == IF_ACC && done)  if_data_o   <= bus_ack_i ? bus_rdata_i : '0;
      if (state == MEM_ACC && done) mem_rdata_o <= bus_ack_i ? bus_rdata_i : '0;
    end
  end

`ifdef BUS_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      err_o <= 1'b0;
    end else begin
      if (start_mem || start_if) cnt <= '0;
      else if (bus_cyc_o)        cnt <= cnt + 32'd1;
      if (timeout) err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

  // Reset gates the stall vector so all outputs read 0 while rst is asserted.
  always_comb begin
    stall_o = 6'b000000;
    if (!rst) begin
      if (mem_req_i && !mem_ack_o)     stall_o = 6'b011111;
      else if (if_req_i && !if_ack_o)  stall_o = 6'b000111;
    end
  end

endmodule

// File: tb/tb_bus_ctrl.sv
module tb_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_cyc_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic [5:0]  stall_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic test_reset();
    rst = 1'b1; if_req_i = 0; if_addr_i = '0; mem_req_i = 0; mem_we_i = 0;
    mem_sel_i = '0; mem_addr_i = '0; mem_wdata_i = '0; bus_rdata_i = '0; bus_ack_i = 0;
    @(negedge clk);
    tests++; if ({bus_cyc_o, if_ack_o, mem_ack_o, stall_o, err_o} !== 10'd0) begin
      fails++; $display("FAIL reset_outputs got %b want 0", {bus_cyc_o, if_ack_o, mem_ack_o, stall_o, err_o}); end
    rst = 1'b0;
    @(negedge clk);
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h40;
    @(negedge clk);
    tests++; if (bus_cyc_o !== 1'b1) begin fails++; $display("FAIL reset_pre_cyc got %b want 1", bus_cyc_o); end
    #1 rst = 1'b1;
    #1;
    tests++; if (bus_cyc_o !== 1'b0) begin fails++; $display("FAIL reset_async_cyc got %b want 0", bus_cyc_o); end
    tests++; if (stall_o !== 6'b000000) begin fails++; $display("FAIL reset_async_stall got %b want 000000", stall_o); end
    mem_req_i = 0; bus_ack_i = 1;
    @(negedge clk);
    bus_ack_i = 0; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if ({mem_ack_o, if_ack_o, bus_cyc_o} !== 3'b000) begin
        fails++; $display("FAIL reset_no_ack[%0d] got %b want 000", i, {mem_ack_o, if_ack_o, bus_cyc_o}); end
    end
  endtask

  task automatic test_if_read();
    if_req_i = 1; if_addr_i = 32'h0000_0010;
    #1;
    tests++; if (stall_o !== 6'b000111) begin fails++; $display("FAIL if_stall_n got %b want 000111", stall_o); end
    @(negedge clk);
    tests++; if ({bus_cyc_o, bus_we_o, bus_sel_o} !== 6'b101111) begin
      fails++; $display("FAIL if_bus_ctl got %b want 101111", {bus_cyc_o, bus_we_o, bus_sel_o}); end
    tests++; if (bus_addr_o !== 32'h10) begin fails++; $display("FAIL if_bus_addr got %h want 00000010", bus_addr_o); end
    tests++; if (stall_o !== 6'b000111 || if_ack_o !== 1'b0) begin
      fails++; $display("FAIL if_stall_n1 got %b/%b want 000111/0", stall_o, if_ack_o); end
    bus_ack_i = 1; bus_rdata_i = 32'h0010_0093;
    @(negedge clk);
    tests++; if ({if_ack_o, bus_cyc_o, stall_o} !== 8'b10_000000) begin
      fails++; $display("FAIL if_ack got %b want 10000000", {if_ack_o, bus_cyc_o, stall_o}); end
    tests++; if (if_data_o !== 32'h0010_0093) begin fails++; $display("FAIL if_data got %h want 00100093", if_data_o); end
    bus_ack_i = 0; if_req_i = 0;
    @(negedge clk);
    tests++; if (if_ack_o !== 1'b0) begin fails++; $display("FAIL if_ack_pulse got %b want 0", if_ack_o); end
  endtask

  task automatic test_priority();
    mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'hF; mem_addr_i = 32'h100; mem_wdata_i = 32'hDEAD_BEEF;
    if_req_i = 1; if_addr_i = 32'h20;
    #1;
    tests++; if (stall_o !== 6'b011111) begin fails++; $display("FAIL prio_stall got %b want 011111", stall_o); end
    @(negedge clk);
    tests++; if ({bus_cyc_o, bus_we_o, bus_sel_o} !== 6'b111111) begin
      fails++; $display("FAIL prio_mem_ctl got %b want 111111", {bus_cyc_o, bus_we_o, bus_sel_o}); end
    tests++; if (bus_addr_o !== 32'h100 || bus_wdata_o !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL prio_mem_addr got %h/%h want 00000100/deadbeef", bus_addr_o, bus_wdata_o); end
    bus_ack_i = 1; bus_rdata_i = 32'h0;
    @(negedge clk);
    tests++; if ({mem_ack_o, if_ack_o} !== 2'b10) begin fails++; $display("FAIL prio_mem_ack got %b want 10", {mem_ack_o, if_ack_o}); end
    bus_ack_i = 0; mem_req_i = 0; mem_we_i = 0;
    #1;
    tests++; if (stall_o !== 6'b000111) begin fails++; $display("FAIL prio_if_stall got %b want 000111", stall_o); end
    @(negedge clk);
    tests++; if (bus_cyc_o !== 1'b0) begin fails++; $display("FAIL prio_gap got %b want 0", bus_cyc_o); end
    @(negedge clk);
    tests++; if ({bus_cyc_o, bus_we_o, bus_sel_o} !== 6'b101111 || bus_addr_o !== 32'h20) begin
      fails++; $display("FAIL prio_if_cyc got %b/%h want 101111/00000020", {bus_cyc_o, bus_we_o, bus_sel_o}, bus_addr_o); end
    bus_ack_i = 1; bus_rdata_i = 32'h1111_1111;
    @(negedge clk);
    tests++; if (if_ack_o !== 1'b1 || if_data_o !== 32'h1111_1111) begin
      fails++; $display("FAIL prio_if_ack got %b/%h want 1/11111111", if_ack_o, if_data_o); end
    bus_ack_i = 0; if_req_i = 0;
    @(negedge clk);
  endtask

  task automatic test_no_preempt();
    if_req_i = 1; if_addr_i = 32'h30;
    @(negedge clk);
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'h3; mem_addr_i = 32'h200;
    #1;
    tests++; if (stall_o !== 6'b011111) begin fails++; $display("FAIL np_stall got %b want 011111", stall_o); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      tests++; if (bus_cyc_o !== 1'b1 || bus_addr_o !== 32'h30 || mem_ack_o !== 1'b0) begin
        fails++; $display("FAIL np_if_wait[%0d] got %b/%h/%b want 1/00000030/0", i, bus_cyc_o, bus_addr_o, mem_ack_o); end
    end
    @(negedge clk);
    bus_ack_i = 1; bus_rdata_i = 32'hAAAA_5555;
    @(negedge clk);
    tests++; if ({if_ack_o, mem_ack_o, stall_o} !== 8'b10_011111 || if_data_o !== 32'hAAAA_5555) begin
      fails++; $display("FAIL np_if_ack got %b/%h want 10011111/aaaa5555", {if_ack_o, mem_ack_o, stall_o}, if_data_o); end
    bus_ack_i = 0; if_req_i = 0;
    @(negedge clk);
    tests++; if (bus_cyc_o !== 1'b0) begin fails++; $display("FAIL np_gap got %b want 0", bus_cyc_o); end
    @(negedge clk);
    tests++; if ({bus_cyc_o, bus_we_o, bus_sel_o} !== 6'b100011 || bus_addr_o !== 32'h200) begin
      fails++; $display("FAIL np_mem_cyc got %b/%h want 100011/00000200", {bus_cyc_o, bus_we_o, bus_sel_o}, bus_addr_o); end
    bus_ack_i = 1; bus_rdata_i = 32'h1234_5678;
    @(negedge clk);
    tests++; if (mem_ack_o !== 1'b1 || mem_rdata_o !== 32'h1234_5678) begin
      fails++; $display("FAIL np_mem_ack got %b/%h want 1/12345678", mem_ack_o, mem_rdata_o); end
    bus_ack_i = 0; mem_req_i = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h300;
    @(negedge clk);
    bus_ack_i = 1; bus_rdata_i = 32'h5A5A_0001;
    @(negedge clk);
    tests++; if (mem_ack_o !== 1'b1) begin fails++; $display("FAIL b2b_ack got %b want 1", mem_ack_o); end
    bus_ack_i = 0;
    @(negedge clk);
    mem_req_i = 0;
    tests++; if (bus_cyc_o !== 1'b0 || mem_ack_o !== 1'b0) begin
      fails++; $display("FAIL b2b_held_req got %b/%b want 0/0", bus_cyc_o, mem_ack_o); end
    bus_ack_i = 1;
    @(negedge clk);
    bus_ack_i = 0;
    tests++; if (bus_cyc_o !== 1'b0) begin fails++; $display("FAIL b2b_no_retrigger got %b want 0", bus_cyc_o); end
    @(negedge clk);
    tests++; if ({mem_ack_o, if_ack_o, bus_cyc_o} !== 3'b000) begin
      fails++; $display("FAIL stray_ack got %b want 000", {mem_ack_o, if_ack_o, bus_cyc_o}); end
  endtask

  task automatic test_timeout();
`ifdef BUS_CTRL_TIMEOUT_EN
    int seen;
    seen = 0;
    if_req_i = 1; if_addr_i = 32'h44;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      @(negedge clk);
      if (if_ack_o === 1'b1) seen = i;
    end
    if_req_i = 0;
    tests++; if (seen != 5) begin fails++; $display("FAIL to_latency got %0d want 5", seen); end
    tests++; if (if_data_o !== 32'h0 || err_o !== 1'b1) begin
      fails++; $display("FAIL to_data_err got %h/%b want 00000000/1", if_data_o, err_o); end
    repeat (3) @(negedge clk);
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL to_sticky got %b want 1", err_o); end
    rst = 1'b1; #1;
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL to_clear got %b want 0", err_o); end
    @(negedge clk); rst = 1'b0;
`else
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_tied got %b want 0", err_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_no_preempt();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
